// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin write arbiter in front of one shared DWIDTH-bit register.
// At most one requester loads the register per clock; grants are registered one-hot acks.
module shared_reg_rr_arbiter #(
    parameter int unsigned             NREQ   = 4,
    parameter int unsigned             DWIDTH = 8,
    parameter logic [DWIDTH-1:0]       RSTVAL = '0,
    localparam int unsigned            IW     = $clog2(NREQ)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic [NREQ-1:0]            i_req,
    input  logic [NREQ*DWIDTH-1:0]     i_wdata,
    output logic [NREQ-1:0]            o_gnt,
    output logic [DWIDTH-1:0]          o_q,
    output logic [IW-1:0]              o_owner,
    output logic                       o_valid,
    output logic                       o_upd
);

    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [DWIDTH-1:0] q_q,     q_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              valid_q, valid_d;
    logic              upd_q,   upd_d;
    logic [IW-1:0]     ptr_q,   ptr_d;

    logic [NREQ-1:0]   eff;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW-1:0]     cand;

    // Last cycle's winner sits out one cycle so a late request drop cannot double-write.
    assign eff = i_req & ~gnt_q;

    // Rotating priority search starting at ptr_q, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = IW'((int'(ptr_q) + i) % int'(NREQ));
            if (!win_found && eff[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_d   = '0;
        upd_d   = 1'b0;
        q_d     = q_q;
        owner_d = owner_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (i_clr) begin
            q_d     = RSTVAL;
            valid_d = 1'b0;
        end else if (win_found) begin
            gnt_d[win_idx] = 1'b1;
            upd_d          = 1'b1;
            q_d            = i_wdata[int'(win_idx)*DWIDTH +: DWIDTH];
            owner_d        = win_idx;
            valid_d        = 1'b1;
            ptr_d          = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_q   <= '0;
            upd_q   <= 1'b0;
            q_q     <= RSTVAL;
            owner_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            gnt_q   <= gnt_d;
            upd_q   <= upd_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_gnt   = gnt_q;
    assign o_upd   = upd_q;
    assign o_q     = q_q;
    assign o_owner = owner_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Directed self-checking bench for shared_reg_rr_arbiter (NREQ=4, DWIDTH=8, RSTVAL=0).
module tb_shared_reg_rr_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   clr;
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [DWIDTH-1:0]      q;
    logic [1:0]             owner;
    logic                   valid;
    logic                   upd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    shared_reg_rr_arbiter #(
        .NREQ   (NREQ),
        .DWIDTH (DWIDTH),
        .RSTVAL (8'h00)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (clr),
        .i_req   (req),
        .i_wdata (wdata),
        .o_gnt   (gnt),
        .o_q     (q),
        .o_owner (owner),
        .o_valid (valid),
        .o_upd   (upd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                              input logic [1:0] e_owner, input logic e_valid);
        check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, ".q"},     32'(q),     32'(e_q));
        check({tag, ".owner"}, 32'(owner), 32'(e_owner));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".upd"},   32'(upd),   32'(|e_gnt));
    endtask

    task automatic set_default_wdata();
        for (int k = 0; k < NREQ; k++) wdata[k*DWIDTH +: DWIDTH] = 8'(8'h10 + k);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        req = 4'b1111;
        set_default_wdata();

        // 1. Reset held with all requesting, then release.
        for (int c = 0; c < 4; c++) begin
            step();
            expect_out($sformatf("rst%0d", c), 4'b0000, 8'h00, 2'd0, 1'b0);
        end
        rst = 1'b0;
        step();
        expect_out("rst_rel", 4'b0001, 8'h10, 2'd0, 1'b1);

        // 2. Single requester: granted every other cycle.
        req = 4'b0010;
        wdata[1*DWIDTH +: DWIDTH] = 8'hA5;
        step(); expect_out("single0", 4'b0010, 8'hA5, 2'd1, 1'b1);
        step(); expect_out("single1", 4'b0000, 8'hA5, 2'd1, 1'b1);
        step(); expect_out("single2", 4'b0010, 8'hA5, 2'd1, 1'b1);
        step(); expect_out("single3", 4'b0000, 8'hA5, 2'd1, 1'b1);

        // 3. Full contention from ptr=0 (reset clears the pointer left at 2).
        set_default_wdata();
        req = 4'b1111;
        rst = 1'b1;
        step(); expect_out("c_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        step(); expect_out("cont0", 4'b0001, 8'h10, 2'd0, 1'b1);
        step(); expect_out("cont1", 4'b0010, 8'h11, 2'd1, 1'b1);
        step(); expect_out("cont2", 4'b0100, 8'h12, 2'd2, 1'b1);
        step(); expect_out("cont3", 4'b1000, 8'h13, 2'd3, 1'b1);
        step(); expect_out("cont4", 4'b0001, 8'h10, 2'd0, 1'b1);
        step(); expect_out("cont5", 4'b0010, 8'h11, 2'd1, 1'b1);

        // 6. Reset mid-rotation: next grant restarts at requester 0.
        rst = 1'b1;
        step(); expect_out("mid_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        rst = 1'b0;
        step(); expect_out("post_rst", 4'b0001, 8'h10, 2'd0, 1'b1);

        // 4. Pointer skip and wrap: after grant to 1, only 3 and 0 request.
        step(); expect_out("wrap_g1", 4'b0010, 8'h11, 2'd1, 1'b1);
        req = 4'b1001;
        step(); expect_out("wrap_g3", 4'b1000, 8'h13, 2'd3, 1'b1);
        step(); expect_out("wrap_g0", 4'b0001, 8'h10, 2'd0, 1'b1);

        // 5. Clear collides with a request; request survives to the next edge.
        req = 4'b1000;
        step(); expect_out("pre_clr", 4'b1000, 8'h13, 2'd3, 1'b1);
        clr = 1'b1;
        req = 4'b0100;
        wdata[2*DWIDTH +: DWIDTH] = 8'h5C;
        step(); expect_out("clr", 4'b0000, 8'h00, 2'd3, 1'b0);
        clr = 1'b0;
        step(); expect_out("post_clr", 4'b0100, 8'h5C, 2'd2, 1'b1);
        req = 4'b0000;
        step(); expect_out("idle", 4'b0000, 8'h5C, 2'd2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shared_reg_rr_arbiter.md
Name: shared_reg_rr_arbiter

Overview:
- Round-robin write arbiter in front of one shared, resettable DWIDTH-bit register (a bank of synchronous-reset DFFs).
- NREQ requesters compete to load the register; at most one write lands per clock.
- The register value, the current owner and a write-acknowledge pulse are exported.
- Used as the sequencing/sharing layer wherever several blocks update a common config/status register.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DWIDTH, 8, register width in bits.
- RSTVAL, 0, value loaded into the register on reset or clear.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_clr  input  1  synchronous clear of register contents; active-high.
- i_req  input  NREQ  write request per requester; bit k = requester k.
- i_wdata  input  NREQ*DWIDTH  packed write data; requester k at [k*DWIDTH +: DWIDTH].
- o_gnt  output  NREQ  registered one-hot grant/ack; all zero when no write occurred.
- o_q  output  DWIDTH  shared register contents.
- o_owner  output  $clog2(NREQ)  index of requester that performed the last write.
- o_valid  output  1  register has been written since last reset/clear.
- o_upd  output  1  one-cycle pulse; high in the cycle after a write edge (equals |o_gnt).

Behaviour:
Reset (i_rst=1 at rising edge), highest priority:
- o_q=RSTVAL, o_gnt=0, o_owner=0, o_valid=0, o_upd=0.
- Internal priority pointer ptr=0.
- All requests are ignored while i_rst=1, including mid-operation.

Arbitration, evaluated each edge with i_rst=0:
- Effective request: eff = i_req & ~o_gnt. A requester granted in the previous cycle is masked for one cycle, so a requester holding i_req continuously is granted at most every other cycle.
- Winner: first k with eff[k]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
- On win at the edge:
  - o_q <= i_wdata[k].
  - o_gnt <= one-hot(k).
  - o_owner <= k.
  - o_valid <= 1.
  - o_upd <= 1.
  - ptr <= (k+1) mod NREQ; wraps from NREQ-1 to 0.
- No winner: o_gnt <= 0, o_upd <= 0; o_q, o_owner, o_valid and ptr hold.

Latency and handshake:
- Data sampled at edge N appears on o_q and o_gnt together after edge N; latency is 1 cycle.
- The requester must hold i_req[k] and i_wdata[k] stable until it sees o_gnt[k]=1, then drop or change them. The masked cycle absorbs a one-cycle-late deassertion without a duplicate write.

Clear (i_clr=1, i_rst=0):
- o_q <= RSTVAL, o_valid <= 0, o_gnt <= 0, o_upd <= 0; o_owner and ptr hold.
- No grant is issued that cycle. Pending requests stay pending and are arbitrated on the next edge with i_clr=0. The o_gnt mask is then all zero.

Other rules:
- Requests from unselected requesters are never dropped silently; they remain pending as long as i_req is held.
- Fairness: with all NREQ requesting continuously, each requester is granted exactly once per NREQ cycles. The self-mask never blocks rotation when NREQ>=2.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (NREQ=4, DWIDTH=8, RSTVAL=0):
1. Reset: hold i_rst=1 for 4 cycles with i_req=4'b1111 -> o_q=0x00, o_gnt=0, o_valid=0, o_upd=0 throughout. First edge after release -> o_gnt=4'b0001, o_q=wdata[0].
2. Single requester: i_req=4'b0010, wdata[1]=0xA5 held 4 cycles -> o_gnt sequence 0010,0000,0010,0000; o_q=0xA5; o_owner=1; o_upd pulses match.
3. Full contention: i_req=4'b1111 held, wdata[k]=0x10+k -> o_gnt 0001,0010,0100,1000,0001; o_q 0x10,0x11,0x12,0x13,0x10.
4. Pointer wrap/skip: after grant to 1, apply i_req=4'b1001 -> grant 1000 (o_q=wdata[3]), then 0001 (o_q=wdata[0]).
5. Clear collision: with o_q=0x13, assert i_clr=1 and i_req=4'b0100 (wdata[2]=0x5C) in the same cycle -> o_q=0x00, o_valid=0, o_gnt=0. Next cycle with i_clr=0 -> o_gnt=0100, o_q=0x5C, o_valid=1.
6. Reset mid-rotation: during scenario 3, pulse i_rst for 1 cycle -> next cycle all outputs at reset values. The following grant goes to requester 0 (ptr=0), regardless of the pre-reset pointer.
